// File: rtl/pipe_pkg.sv
// Shared pipeline-stage widths and payload field offsets. Stages pack their
// fields into flat data/ctrl vectors using these offsets before pipe_stage_buf.
package pipe_pkg;

    localparam int IFID_DATA_W  = 64;   // IR, PC
    localparam int IFID_CTRL_W  = 1;
    localparam int IDEX_DATA_W  = 197;
    localparam int IDEX_CTRL_W  = 16;
    localparam int EXMEM_DATA_W = 197;  // IR, PC, RES, HI, LO, STORE, WB_REG
    localparam int EXMEM_CTRL_W = 10;
    localparam int MEMWB_DATA_W = 165;
    localparam int MEMWB_CTRL_W = 6;

    // EX/MEM datapath field offsets (LSB of each field)
    localparam int EXMEM_IR_OFS     = 0;
    localparam int EXMEM_PC_OFS     = 32;
    localparam int EXMEM_RES_OFS    = 64;
    localparam int EXMEM_HI_OFS     = 96;
    localparam int EXMEM_LO_OFS     = 128;
    localparam int EXMEM_STORE_OFS  = 160;
    localparam int EXMEM_WBREG_OFS  = 192;
    localparam int EXMEM_WBREG_W    = 5;

    // EX/MEM control bit positions
    localparam int CTRL_REGWRITE      = 0;
    localparam int CTRL_LOWRITE       = 1;
    localparam int CTRL_HIWRITE       = 2;
    localparam int CTRL_MEMTOREG      = 3;
    localparam int CTRL_JAL           = 4;
    localparam int CTRL_SYSCALL       = 5;
    localparam int CTRL_MEMWRITE      = 6;
    localparam int CTRL_UNSIGNEDEXT   = 7;
    localparam int CTRL_BYTE          = 8;
    localparam int CTRL_HALF          = 9;

    typedef struct packed {
        logic half;
        logic byte_en;
        logic unsigned_ext_mem;
        logic mem_write;
        logic syscall;
        logic jal;
        logic mem_to_reg;
        logic hi_write;
        logic lo_write;
        logic reg_write;
    } exmem_ctrl_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One storage slot (valid + data + ctrl). Clear wins over load and zeroes
// the whole entry.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = EXMEM_DATA_W,
    parameter int CTRL_W = EXMEM_CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            ctrl_q  <= ctrl_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer,
// flush, bubble insertion and a saturating stall counter.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = EXMEM_DATA_W,
    parameter int                CTRL_W      = EXMEM_CTRL_W,
    parameter logic [DATA_W-1:0] BUBBLE_KEEP = '1,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              bb,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_v, skid_v;
    logic [DATA_W-1:0] main_data, skid_data, in_data_eff, main_data_d;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, in_ctrl_eff, main_ctrl_d;
    logic              accept, deliver;
    logic              main_load, main_clear, skid_load, skid_clear;
    logic              skid_v_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    assign accept      = in_valid & in_ready_q;
    assign deliver     = main_v & out_ready;
    assign in_data_eff = bb ? (in_data & BUBBLE_KEEP) : in_data;
    assign in_ctrl_eff = bb ? '0 : in_ctrl;

    // Main refills from skid first to keep FIFO order; accept only reaches
    // skid when main is occupied and not leaving this cycle.
    always_comb begin
        main_load   = 1'b0;
        main_clear  = 1'b0;
        skid_load   = 1'b0;
        skid_clear  = 1'b0;
        main_data_d = in_data_eff;
        main_ctrl_d = in_ctrl_eff;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (!main_v || deliver) begin
            if (skid_v) begin
                main_load   = 1'b1;
                main_data_d = skid_data;
                main_ctrl_d = skid_ctrl;
                skid_clear  = 1'b1;
            end else if (accept) begin
                main_load = 1'b1;
            end else if (main_v) begin
                main_clear = 1'b1;
            end
        end else if (accept) begin
            skid_load = 1'b1;
        end
    end

    assign skid_v_d   = !flush && (skid_load || (skid_v && !skid_clear));
    assign in_ready_d = !skid_v_d;

    assign stall_cnt_d = (main_v && !out_ready && !(&stall_cnt_q))
                       ? stall_cnt_q + 1'b1 : stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load_i  (main_load),
        .clear_i (main_clear),
        .data_i  (main_data_d),
        .ctrl_i  (main_ctrl_d),
        .valid_o (main_v),
        .data_o  (main_data),
        .ctrl_o  (main_ctrl)
    );

    pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (in_data_eff),
        .ctrl_i  (in_ctrl_eff),
        .valid_o (skid_v),
        .data_o  (skid_data),
        .ctrl_o  (skid_ctrl)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = main_v;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed + random bench for pipe_stage_buf against a queue-based model of
// the stored beats (capacity two, FIFO order, flush empties it).
module tb_pipe_stage_buf;

    localparam int DW = 197;
    localparam int CW = 10;
    localparam int NW = 4;
    localparam logic [199:0] KEEP_FULL = {25{8'h0F}};
    localparam logic [DW-1:0] KEEP = KEEP_FULL[DW-1:0];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0, bb = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [NW-1:0] stall_cnt;

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;

    beat_t         mq[$];
    int            exp_cnt = 0;
    bit            last_acc;
    int            checks = 0;
    int            errors = 0;

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_KEEP(KEEP), .CNT_W(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bb        (bb),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rdata();
        logic [223:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return w[DW-1:0];
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, out_valid, mq.size() > 0);
        chk({tag, ".in_ready"}, in_ready, mq.size() < 2);
        chk({tag, ".stall_cnt"}, stall_cnt, exp_cnt);
        if (mq.size() > 0) begin
            chk({tag, ".out_data"}, out_data, mq[0].d);
            chk({tag, ".out_ctrl"}, out_ctrl, mq[0].c);
        end
    endtask

    // One clock: model decides accept/deliver from pre-edge state, then compares.
    task automatic cycle(input string tag);
        bit    acc, del, st;
        beat_t b;
        acc = in_valid && (mq.size() < 2);
        del = (mq.size() > 0) && out_ready;
        st  = (mq.size() > 0) && !out_ready;
        @(posedge clk);
        #1;
        if (st && exp_cnt < (2**NW - 1)) exp_cnt++;
        if (flush) begin
            mq.delete();
        end else begin
            if (del) void'(mq.pop_front());
            if (acc) begin
                b.d = bb ? (in_data & KEEP) : in_data;
                b.c = bb ? '0 : in_ctrl;
                mq.push_back(b);
            end
        end
        last_acc = acc && !flush;
        check_outputs(tag);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        mq.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // reset values
        #12;
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.out_data", out_data, '0);
        chk("rst.out_ctrl", out_ctrl, '0);
        chk("rst.stall_cnt", stall_cnt, '0);
        chk("rst.in_ready", in_ready, 1'b1);
        rst = 1'b0;

        // stream 1..8 with ctrl=3FF
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            in_ctrl  = 10'h3FF;
            cycle("stream");
            chk("stream.data_seq", out_data, i);
        end
        in_valid = 1'b0;
        cycle("stream_drain");

        // backpressure: A, B accepted, C held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = rdata(); in_ctrl = 10'h0A1; cycle("bp_A");
        in_data = rdata(); in_ctrl = 10'h0B2; cycle("bp_B");
        in_data = rdata(); in_ctrl = 10'h0C3; cycle("bp_C0");
        chk("bp.in_ready_low", in_ready, 1'b0);
        cycle("bp_C1");
        chk("bp.stall_count", stall_cnt, 4'd3);
        out_ready = 1'b1;
        for (int k = 0; k < 6 && in_valid; k++) begin
            cycle("bp_release");
            if (last_acc) in_valid = 1'b0;
        end
        for (int k = 0; k < 3; k++) cycle("bp_drain");

        // bubble
        in_valid = 1'b1;
        bb       = 1'b1;
        in_data  = '1;
        in_ctrl  = 10'h155;
        out_ready = 1'b0;
        cycle("bubble");
        chk("bubble.out_data", out_data, KEEP);
        chk("bubble.out_ctrl", out_ctrl, '0);
        chk("bubble.out_valid", out_valid, 1'b1);
        bb = 1'b0;

        // flush while FULL, with a new beat presented
        in_data = rdata(); in_ctrl = 10'h111; cycle("fill");
        chk("full.in_ready", in_ready, 1'b0);
        flush = 1'b1; in_data = rdata(); in_ctrl = 10'h222;
        cycle("flush_full");
        chk("flush_full.out_valid", out_valid, 1'b0);
        chk("flush_full.out_ctrl", out_ctrl, '0);
        chk("flush_full.in_ready", in_ready, 1'b1);
        // flush with ONE and in_ready=1: the presented beat is dropped
        flush = 1'b0; in_data = rdata(); cycle("one");
        flush = 1'b1; bb = 1'b1; in_data = rdata(); cycle("flush_one");
        chk("flush_one.out_valid", out_valid, 1'b0);
        flush = 1'b0; bb = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) cycle("post_flush");

        // async reset while FULL and stalled
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = rdata(); cycle("ar_A");
        in_data = rdata(); cycle("ar_B");
        in_valid = 1'b0;
        cycle("ar_stall");
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst.out_valid", out_valid, 1'b0);
        chk("async_rst.stall_cnt", stall_cnt, '0);
        chk("async_rst.in_ready", in_ready, 1'b1);
        mq.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;

        // saturation
        in_valid = 1'b1; in_data = rdata(); cycle("sat_load");
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) cycle("sat");
        chk("sat.stall_cnt", stall_cnt, 4'd15);

        // randomized traffic
        reset_pulse();
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            bb        = in_valid && ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_data   = rdata();
            in_ctrl   = CW'($urandom);
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
